// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, FSM state and helper definitions for the ALU round-robin scheduler.
package alu_ctrl_pkg;

    localparam int unsigned OP_CODE_W = 2;

    localparam logic [OP_CODE_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_CODE_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_CODE_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_CODE_W-1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Only the arithmetic opcodes produce a meaningful carry from the ALU.
    function automatic logic op_has_carry(input logic [OP_CODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
//   req       : per-requester request lines
//   ptr       : highest-priority index for this decision (must be < N_REQ)
//   gnt       : one-hot grant (all zero when nothing requests)
//   gnt_idx   : binary index of the granted requester
//   gnt_valid : high when some requester is granted
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_valid
);

    // Modular add for index rotation; N_REQ need not be a power of two.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off);
        int unsigned sum;
        sum = base + off;
        return (sum >= N_REQ) ? (sum - N_REQ) : sum;
    endfunction

    // Scan priority order ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!gnt_valid && req[j] && (j == wrap_add(32'(ptr), k))) begin
                    gnt[j]    = 1'b1;
                    gnt_idx   = ID_W'(j);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external ALU among N_REQ requesters with round-robin arbitration.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester handshake; req_ready is a one-hot accept pulse
//   req_a/b/op        : packed per-requester operands and opcode (slice i = requester i)
//   alu_a/b/op        : registered operands driven to the ALU
//   alu_result/carry/zero : combinational ALU outputs
//   rsp_valid/ready   : response handshake
//   rsp_id/result/carry/zero : captured response tagged with the owning requester
//   busy              : high whenever the FSM is not idle
module alu_rr_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned OP_W   = 2,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic                    busy
);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     ptr_next;
    logic [N_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;
    logic                rsp_fire;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign rsp_fire = rsp_valid && rsp_ready;

    // Priority moves to the requester after the one just served.
    assign ptr_next = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : (rsp_id + ID_W'(1));

    // One-hot operand mux driven by the arbiter grant.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept pulse only while idle, busy otherwise.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == S_IDLE) begin
            req_ready = arb_gnt;
        end else begin
            busy = 1'b1;
        end
    end

    // Operand, response and pointer registers; alu_* only load on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 1'b0;
            ptr_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        rsp_id <= arb_idx;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    // Carry is undefined from the ALU for logic ops.
                    rsp_carry  <= op_has_carry(OP_CODE_W'(alu_op)) ? alu_carry : 1'b0;
                    rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        ptr_q     <= ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
